stream_mux_n: RTL and testbench

//  Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake on every port.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/stream_mux_n.sv | 132 +++++++++++++
 tb/tb_stream_mux_n.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and constants for the stream multiplexer
package mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Smallest r with 2**r >= n; used to size channel ids.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority request search
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_id,
  output logic             gnt_any
);

  int idx;

  // Walk offsets from farthest to nearest so the request closest to ptr wins.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      for (int j = 0; j < N; j++) begin
        if (j == idx && req[j]) begin
          gnt_id  = SEL_W'(j);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N:1 registered stream mux with packet-locked grant
module stream_mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = clog2(N),
  parameter int MODE  = MODE_SEL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               out_valid_q, out_valid_d;

  logic [SEL_W-1:0]   g;
  logic               grant_ok;
  logic               vld_g;
  logic               last_g;
  logic [WIDTH-1:0]   data_g;
  logic               load_en;
  logic               xfer;
  logic [SEL_W-1:0]   arb_id;
  logic               arb_any;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_id  (arb_id),
    .gnt_any (arb_any)
  );

  // Pick the granted channel, mux its beat and derive the handshake.
  // An out-of-range sel matches no channel, so it can never grant.
  always_comb begin
    g        = '0;
    vld_g    = 1'b0;
    last_g   = 1'b0;
    data_g   = '0;
    grant_ok = 1'b0;
    in_ready = '0;
    if (state_q == LOCKED) g = lock_ch_q;
    else if (MODE == MODE_RR) g = arb_id;
    else g = sel;
    for (int i = 0; i < N; i++) begin
      if (g == SEL_W'(i)) begin
        vld_g  = in_valid[i];
        last_g = in_last[i];
        data_g = in_data[i*WIDTH +: WIDTH];
      end
    end
    if (state_q == IDLE && MODE == MODE_RR) grant_ok = vld_g & arb_any;
    else grant_ok = vld_g;
    load_en = ~out_valid_q | out_ready;
    xfer    = load_en & grant_ok & rst_n;
    for (int i = 0; i < N; i++) begin
      if (xfer && g == SEL_W'(i)) in_ready[i] = 1'b1;
    end
  end

  // Next output register contents, lock tracking and round-robin pointer.
  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = data_g;
      out_last_d  = last_g;
      out_ch_d    = g;
      out_valid_d = 1'b1;
      if (last_g) begin
        state_d = IDLE;
        if (MODE == MODE_RR) rr_ptr_d = (g == SEL_W'(N - 1)) ? '0 : g + SEL_W'(1);
      end else begin
        state_d   = LOCKED;
        lock_ch_d = g;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // All state updates; reset drops any partial packet and releases the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - directed self-checking bench for stream_mux_n
module tb_stream_mux_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // u0: explicit select, N=4
  logic [31:0] in_data0;
  logic [3:0]  in_last0, in_valid0, in_ready0;
  logic [1:0]  sel0, out_ch0;
  logic [7:0]  out_data0;
  logic        out_last0, out_valid0, out_ready0;

  // u1: round robin, N=4
  logic [31:0] in_data1;
  logic [3:0]  in_last1, in_valid1, in_ready1;
  logic [1:0]  sel1, out_ch1;
  logic [7:0]  out_data1;
  logic        out_last1, out_valid1, out_ready1;

  // u2: explicit select, N=3
  logic [23:0] in_data2;
  logic [2:0]  in_last2, in_valid2, in_ready2;
  logic [1:0]  sel2, out_ch2;
  logic [7:0]  out_data2;
  logic        out_last2, out_valid2, out_ready2;

  stream_mux_n #(.WIDTH(8), .N(4), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_last(in_last0),
    .in_valid(in_valid0), .in_ready(in_ready0), .sel(sel0), .out_data(out_data0),
    .out_last(out_last0), .out_ch(out_ch0), .out_valid(out_valid0), .out_ready(out_ready0));

  stream_mux_n #(.WIDTH(8), .N(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_last(in_last1),
    .in_valid(in_valid1), .in_ready(in_ready1), .sel(sel1), .out_data(out_data1),
    .out_last(out_last1), .out_ch(out_ch1), .out_valid(out_valid1), .out_ready(out_ready1));

  stream_mux_n #(.WIDTH(8), .N(3), .MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_last(in_last2),
    .in_valid(in_valid2), .in_ready(in_ready2), .sel(sel2), .out_data(out_data2),
    .out_last(out_last2), .out_ch(out_ch2), .out_valid(out_valid2), .out_ready(out_ready2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_data0 = '0; in_last0 = '0; in_valid0 = '0; sel0 = '0; out_ready0 = 1'b1;
    in_data1 = '0; in_last1 = '0; in_valid1 = '0; sel1 = '0; out_ready1 = 1'b1;
    in_data2 = '0; in_last2 = '0; in_valid2 = '0; sel2 = '0; out_ready2 = 1'b1;
    #3;
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_out_ch", out_ch0, 0);
    check("rst_in_ready", in_ready0, 0);
    tick();
    rst_n = 1'b1;

    // 1: single beat through sel=2
    sel0 = 2'd2; in_valid0 = 4'b0100; in_data0[16 +: 8] = 8'hA5; in_last0 = 4'b0100;
    #1 check("t1_in_ready", in_ready0, 4'b0100);
    tick();
    check("t1_out_valid", out_valid0, 1);
    check("t1_out_data", out_data0, 8'hA5);
    check("t1_out_ch", out_ch0, 2);
    check("t1_out_last", out_last0, 1);
    in_valid0 = '0;
    tick();
    check("t1_drain", out_valid0, 0);

    // 2: lock on ch1 while sel moves to ch3
    sel0 = 2'd1; in_valid0 = 4'b1010; in_data0[8 +: 8] = 8'h11; in_data0[24 +: 8] = 8'h44;
    in_last0 = 4'b1000;
    #1 check("t2_rdy_b1", in_ready0, 4'b0010);
    tick();
    check("t2_b1_data", out_data0, 8'h11);
    check("t2_b1_ch", out_ch0, 1);
    sel0 = 2'd3; in_data0[8 +: 8] = 8'h22;
    #1 check("t2_rdy_locked", in_ready0, 4'b0010);
    tick();
    check("t2_b2_data", out_data0, 8'h22);
    check("t2_b2_ch", out_ch0, 1);
    in_data0[8 +: 8] = 8'h33; in_last0 = 4'b1010;
    tick();
    check("t2_b3_data", out_data0, 8'h33);
    check("t2_b3_last", out_last0, 1);
    in_valid0 = 4'b1000;
    #1 check("t2_rdy_ch3", in_ready0, 4'b1000);
    tick();
    check("t2_ch3_data", out_data0, 8'h44);
    check("t2_ch3_ch", out_ch0, 3);

    // 4: backpressure holds output and blocks input
    sel0 = 2'd0; in_valid0 = 4'b0001; in_data0[7:0] = 8'h50; in_last0 = 4'b0001;
    tick();
    check("t4_first", out_data0, 8'h50);
    out_ready0 = 1'b0; in_data0[7:0] = 8'h51;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_bp_rdy", in_ready0, 0);
      check("t4_bp_data", out_data0, 8'h50);
      check("t4_bp_valid", out_valid0, 1);
      tick();
    end
    out_ready0 = 1'b1;
    #1 check("t4_rel_rdy", in_ready0, 4'b0001);
    tick();
    check("t4_b51", out_data0, 8'h51);
    in_data0[7:0] = 8'h52;
    tick();
    check("t4_b52", out_data0, 8'h52);
    check("t4_b52_valid", out_valid0, 1);
    in_valid0 = '0;
    tick();
    check("t4_end", out_valid0, 0);

    // 5: out-of-range select on N=3 never grants
    sel2 = 2'd3; in_valid2 = 3'b111; in_last2 = 3'b111;
    in_data2 = {8'h72, 8'h71, 8'h70};
    #1 check("t5_rdy", in_ready2, 0);
    tick();
    check("t5_valid_a", out_valid2, 0);
    tick();
    check("t5_valid_b", out_valid2, 0);
    sel2 = 2'd2;
    #1 check("t5_rdy_ch2", in_ready2, 3'b100);
    tick();
    check("t5_data_ch2", out_data2, 8'h72);
    check("t5_ch2", out_ch2, 2);
    in_valid2 = '0;

    // 3: round robin over four single-beat sources
    in_valid1 = 4'b1111; in_last1 = 4'b1111; in_data1 = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    #1 check("t3_rdy0", in_ready1, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_ch", out_ch1, k % 4);
      check("t3_data", out_data1, 8'hC0 + (k % 4));
    end

    // 6: lock in round-robin mode, then reset mid-packet
    in_valid1 = 4'b0100; in_last1 = 4'b0000; in_data1[16 +: 8] = 8'hD0;
    #1 check("t6_rdy_b1", in_ready1, 4'b0100);
    tick();
    check("t6_b1_ch", out_ch1, 2);
    in_valid1 = 4'b1111; in_data1[16 +: 8] = 8'hD1;
    #1 check("t6_rdy_locked", in_ready1, 4'b0100);
    tick();
    check("t6_b2_data", out_data1, 8'hD1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid1, 0);
    check("t6_rst_data", out_data1, 0);
    check("t6_rst_ch", out_ch1, 0);
    check("t6_rst_rdy", in_ready1, 0);
    tick();
    rst_n = 1'b1;
    #1 check("t6_post_rr0", in_ready1, 4'b0001);
    in_valid1 = 4'b1000;
    #1 check("t6_post_ch3", in_ready1, 4'b1000);
    in_valid1 = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
